button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner_pkg.sv | 19 +
 rtl/button_conditioner_debounce_cell.sv | 119 +++++++++++
 rtl/button_conditioner.sv | 33 +++
 tb/tb_button_conditioner.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared types and constants for the pushbutton conditioner.
// Holds the per-channel debounce FSM state type and the default debounce length.
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        WAIT_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        WAIT_LOW    = 2'd3
    } btn_state_t;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 16;

    // Counter must hold DEBOUNCE_CYCLES-1 with one bit of headroom.
    function automatic int unsigned count_width(input int unsigned cycles);
        return $clog2(cycles) + 1;
    endfunction

endpackage

// File: rtl/button_conditioner_debounce_cell.sv
// One pushbutton channel: two-flop synchronizer, debounce FSM with stability counter,
// and registered level / press / release outputs.
module debounce_cell
    import button_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int unsigned      CNT_W    = count_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    btn_state_t       r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_level;
    logic             r_press;
    logic             r_release;

    logic             w_synced;
    btn_state_t       w_state_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_level_nxt;
    logic             w_press_nxt;
    logic             w_release_nxt;

    assign w_synced = r_sync2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= STABLE_LOW;
            r_count   <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_level   <= w_level_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
        end
    end

    // Count clears on every path except an in-progress WAIT that still sees the new level.
    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = '0;
        w_level_nxt   = r_level;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        unique case (r_state)
            STABLE_LOW: begin
                if (w_synced) begin
                    w_state_nxt = WAIT_HIGH;
                    w_count_nxt = CNT_ONE;
                end
            end
            WAIT_HIGH: begin
                if (!w_synced) begin
                    w_state_nxt = STABLE_LOW;
                end else if (r_count == CNT_LAST) begin
                    w_state_nxt = STABLE_HIGH;
                    w_level_nxt = 1'b1;
                    w_press_nxt = 1'b1;
                end else begin
                    w_count_nxt = r_count + 1'b1;
                end
            end
            STABLE_HIGH: begin
                if (!w_synced) begin
                    w_state_nxt = WAIT_LOW;
                    w_count_nxt = CNT_ONE;
                end
            end
            WAIT_LOW: begin
                if (w_synced) begin
                    w_state_nxt = STABLE_HIGH;
                end else if (r_count == CNT_LAST) begin
                    w_state_nxt   = STABLE_LOW;
                    w_level_nxt   = 1'b0;
                    w_release_nxt = 1'b1;
                end else begin
                    w_count_nxt = r_count + 1'b1;
                end
            end
            default: begin
                w_state_nxt = STABLE_LOW;
                w_level_nxt = 1'b0;
            end
        endcase
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

    a_count_bound: assert property (@(posedge clk) disable iff (!reset) r_count <= CNT_LAST);
    a_pulse_excl:  assert property (@(posedge clk) disable iff (!reset) !(r_press && r_release));

endmodule

// File: rtl/button_conditioner.sv
// Pushbutton conditioner: N_BTN independent debounce channels feeding the processor's
// PUSHBUTTONS bus with a clean level plus one-cycle press/release strobes.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned N_BTN           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] raw_btn,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse
);

    genvar g;
    generate
        for (g = 0; g < int'(N_BTN); g++) begin : g_cell
            debounce_cell #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_cell (
                .clk      (clk),
                .reset    (reset),
                .i_raw    (raw_btn[g]),
                .o_level  (btn_level[g]),
                .o_press  (press_pulse[g]),
                .o_release(release_pulse[g])
            );
        end
    endgenerate

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: a run-length reference model predicts each
// cycle's outputs, a separate monitor pops and compares on the falling edge.
module tb_button_conditioner;

    localparam int unsigned N = 4;
    localparam int unsigned D = 4;

    logic         clk     = 1'b0;
    logic         reset   = 1'b0;
    logic [N-1:0] raw_btn = '0;
    logic [N-1:0] btn_level;
    logic [N-1:0] press_pulse;
    logic [N-1:0] release_pulse;

    always #5 clk = ~clk;

    button_conditioner #(
        .N_BTN          (N),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .raw_btn      (raw_btn),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse)
    );

    typedef struct packed {
        logic [N-1:0] level;
        logic [N-1:0] press;
        logic [N-1:0] rel;
    } exp_t;

    exp_t         sb_q[$];
    logic [N-1:0] delay_q[$];
    logic [N-1:0] m_level;
    int unsigned  m_run[N];
    int unsigned  obs_press[N];
    int           checks  = 0;
    int           errors  = 0;
    bit           started = 1'b0;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: the FSM sees raw delayed by two edges; a level flips once the delayed value
    // has disagreed with the current level for D consecutive edges.
    always @(posedge clk) begin : model
        exp_t         e;
        logic [N-1:0] s;
        e = '0;
        if (!reset) begin
            delay_q.delete();
            delay_q.push_back('0);
            delay_q.push_back('0);
            m_level = '0;
            for (int i = 0; i < int'(N); i++) m_run[i] = 0;
        end else begin
            delay_q.push_back(raw_btn);
            s = delay_q.pop_front();
            for (int i = 0; i < int'(N); i++) begin
                if (s[i] != m_level[i]) m_run[i]++;
                else                    m_run[i] = 0;
                if (m_run[i] == D) begin
                    m_level[i] = ~m_level[i];
                    if (m_level[i]) e.press[i] = 1'b1;
                    else            e.rel[i]   = 1'b1;
                    m_run[i] = 0;
                end
            end
        end
        e.level = m_level;
        sb_q.push_back(e);
        started = 1'b1;
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (started) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
            end else begin
                e = sb_q.pop_front();
                if (!reset) e = '0;
                check("btn_level", btn_level, e.level);
                check("press_pulse", press_pulse, e.press);
                check("release_pulse", release_pulse, e.rel);
            end
            for (int i = 0; i < int'(N); i++)
                if (press_pulse[i]) obs_press[i]++;
        end
    end

    task automatic hold(input logic [N-1:0] v, input int unsigned cycles);
        raw_btn = v;
        repeat (cycles) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic reset_pulse(input int unsigned cycles);
        reset = 1'b0;
        #1;
        check("reset_level", btn_level, '0);
        check("reset_press", press_pulse, '0);
        check("reset_release", release_pulse, '0);
        repeat (cycles) @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    initial begin : watchdog
        #200000;
        errors++;
        $display("FAIL watchdog at %0t: got timeout expected finish", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : stim
        int unsigned p;
        for (int i = 0; i < int'(N); i++) obs_press[i] = 0;
        reset   = 1'b0;
        raw_btn = 4'b0001;
        repeat (3) @(posedge clk);
        #2;
        check("in_reset_level", btn_level, '0);
        reset = 1'b1;

        // held across reset release
        p = obs_press[0];
        hold(4'b0001, 10);
        check_int("press_once_ch0", obs_press[0] - p, 1);
        hold(4'b0000, 10);

        // fast toggling on channel 1
        p = obs_press[1];
        for (int i = 0; i < 8; i++) hold((i % 2 == 0) ? 4'b0010 : 4'b0000, 1);
        hold(4'b0000, 10);
        check_int("toggle_no_press_ch1", obs_press[1] - p, 0);

        // 3-cycle vs 4-cycle high on channel 2
        p = obs_press[2];
        hold(4'b0100, 3);
        hold(4'b0000, 10);
        check_int("short_high_ch2", obs_press[2] - p, 0);
        hold(4'b0100, 4);
        hold(4'b0000, 12);
        check_int("min_high_ch2", obs_press[2] - p, 1);

        // all channels at once
        hold(4'b1111, 10);
        hold(4'b0000, 10);

        // reset in the middle of WAIT_HIGH on channel 3
        p = obs_press[3];
        hold(4'b1000, 4);
        reset_pulse(2);
        check_int("no_press_before_reset_ch3", obs_press[3] - p, 0);
        hold(4'b1000, 10);
        check_int("press_after_reset_ch3", obs_press[3] - p, 1);
        hold(4'b0000, 10);

        // long hold, no auto-repeat
        p = obs_press[0];
        hold(4'b0001, 100);
        check_int("long_hold_ch0", obs_press[0] - p, 1);
        check("long_hold_level", btn_level, 4'b0001);
        hold(4'b0000, 10);

        for (int k = 0; k < 80; k++) begin
            if ($urandom_range(0, 24) == 0) reset_pulse($urandom_range(1, 3));
            hold(N'($urandom_range(0, 15)), $urandom_range(1, 8));
        end

        hold(4'b0000, 12);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
